// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), processed
// BITS_PER_CYCLE bits per clock, LSB first, through a registered borrow chain.
// Valid/ready handshake on input and output. FSM: IDLE -> RUN -> DONE -> IDLE.
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
//   When defined, adds o_ovf (signed two's-complement overflow of a - b - bin),
//   registered and held alongside o_diff.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operands and borrow-in are valid
//   o_in_ready   block can accept operands (high only in IDLE)
//   i_a, i_b     minuend / subtrahend (WIDTH bits)
//   i_bin        borrow in
//   o_out_valid  o_diff / o_borrow are valid (DONE)
//   i_out_ready  consumer accepts the result
//   o_diff       a - b - bin, mod 2^WIDTH
//   o_borrow     1 iff a < b + bin (unsigned)
//   o_busy       high in RUN
//   o_ovf        signed overflow (SERIAL_SUBTRACTOR_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_busy
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam int unsigned BPC = BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    // r_a doubles as the result register: each step shifts the operand right
    // and inserts the fresh difference chunk at the MSB end, so after STEPS
    // steps it holds the complete result.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_out_valid;
    logic             r_busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of r_a/r_b during RUN, so keep copies.
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic [BPC:0]     w_chunk;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    // Extra MSB of the (BPC+1)-bit difference is the chunk borrow.
    assign w_chunk = {1'b0, r_a[BPC-1:0]} - {1'b0, r_b[BPC-1:0]} - {{BPC{1'b0}}, r_brw};

    generate
        if (WIDTH > BPC) begin : gen_shift
            assign w_a_next = {w_chunk[BPC-1:0], r_a[WIDTH-1:BPC]};
            assign w_b_next = {{BPC{1'b0}}, r_b[WIDTH-1:BPC]};
        end else begin : gen_single
            assign w_a_next = w_chunk[BPC-1:0];
            assign w_b_next = '0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_brw       <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_brw   <= i_bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_a_msb <= i_a[WIDTH-1];
                        r_b_msb <= i_b[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_brw <= w_chunk[BPC];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_diff      <= w_a_next;
                        r_borrow    <= w_chunk[BPC];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StDone;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_ovf <= (r_a_msb ^ r_b_msb) & (w_a_next[WIDTH-1] ^ r_a_msb);
`endif
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_diff      = r_diff;
    assign o_borrow    = r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign o_ovf       = r_ovf;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, multi-cycle successor to the single-bit half/full subtractor cells.
- Computes diff = a - b - bin on WIDTH-bit unsigned operands, BITS_PER_CYCLE bits per clock, LSB first, through a registered borrow chain.
- Uses a valid/ready handshake on both input and output.
- Intended as the area-lean arithmetic primitive for datapaths that tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly. STEPS = WIDTH / BITS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and bin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  diff/borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, mod 2^WIDTH.
- borrow  output  1  borrow out; 1 iff a < b + bin (unsigned).
- busy  output  1  high in RUN.

Behaviour:
- Reset: one clock, asynchronous, active-low (clk, rst_n).
  - rst_n low forces state IDLE immediately, without waiting for a clock edge.
  - Reset values: diff=0, borrow=0, out_valid=0, busy=0, step counter=0, internal shift registers=0.
  - in_ready decodes from state, so it reads 1 while in reset.
- State machine, IDLE -> RUN -> DONE -> IDLE:
  - IDLE: in_ready=1. Edge with in_valid=1 loads a and b into shift registers, loads the borrow register from bin, clears the counter, and moves to RUN. in_valid=0 stays in IDLE.
  - RUN: each edge takes the low BITS_PER_CYCLE bits of each operand register and computes chunk = a_lo - b_lo - borrow_reg.
    - The low BITS_PER_CYCLE bits of chunk shift into the result register from the MSB side.
    - borrow_reg takes the chunk borrow.
    - The operand registers shift right by BITS_PER_CYCLE and the counter increments.
    - On the edge where counter == STEPS-1, move to DONE.
  - DONE: out_valid=1. diff and borrow hold stable until an edge with out_ready=1, which returns the block to IDLE with out_valid=0.
- Output timing:
  - diff and borrow are registered and change only when entering DONE.
  - Outside DONE they hold the last result; they are 0 after reset.
- Latency: if acceptance happens at edge E, out_valid is high after edge E+STEPS.
  - Minimum throughput is one result per STEPS+2 cycles.
  - There is no accept in the same cycle as result drain.
- Boundary rules:
  - in_valid is ignored in RUN and DONE. Operand inputs are sampled only at the accept edge, so later changes have no effect.
  - out_ready held low: stall indefinitely in DONE with outputs stable.
  - out_ready high outside DONE: no effect.
  - WIDTH=1, bin=0: diff = a XOR b, borrow = ~a & b, which is the half-subtractor truth table.
  - Wrap-around: the result is modulo 2^WIDTH. For example, 0 - 0 - 1 gives diff all ones, borrow=1.
  - Reset asserted mid-RUN or in DONE: the operation is aborted and the result is lost. After release the block is in IDLE with in_ready=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of a - b - bin.
  - ovf = 1 when the sign of a differs from the sign of b and the sign of diff differs from the sign of a.
  - Registered with diff; reset value 0; held with diff.
- Undefined: ovf port is absent and no overflow logic exists. All other behaviour is identical.

Test Plan:
- WIDTH=8, BPC=1; a=0x05, b=0x03, bin=0 -> out_valid exactly 8 cycles after accept, diff=0x02, borrow=0.
- WIDTH=8, BPC=1; a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1.
- WIDTH=8, BPC=4; a=0xA7, b=0x3C, bin=1 -> out_valid after 2 cycles, diff=0x6A, borrow=0. Exhaustive WIDTH=1 sweep matches the half-subtractor truth table.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> in_ready=0, diff/borrow/out_valid stable. Next accept occurs only after the drain cycle.
- Reset: assert rst_n=0 asynchronously at step 4 of 8 -> outputs go to 0 before the next clock edge, in_ready=1. A fresh op 0x10 - 0x01 then gives diff=0x0F.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x7F, b=0x01 -> diff=0x7E, ovf=0. Without the macro, the bench compiles without ovf and the other results are unchanged.
